// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state, bus width default and response encodings for the APB completer
package apb_pkg;
  localparam int DEF_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERROR = 1'b1;
endpackage

// File: rtl/apb_completer_regs.sv
// apb_completer_regs: word storage with a read-only transfer counter in the top slot
module apb_completer_regs
  import apb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 16
) (
  input  logic                     pclk,
  input  logic                     preset_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     inc,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] cnt_q, cnt_d;
  // the top slot is never written; reads of it return the counter instead
  always_comb begin
    mem_d = mem_q;
    if (we && waddr != AW'(DEPTH - 1)) mem_d[waddr] = wdata;
    cnt_d = inc ? cnt_q + 1'b1 : cnt_q;
    rdata = raddr == AW'(DEPTH - 1) ? cnt_q : mem_q[raddr];
  end
  always_ff @(posedge pclk or negedge preset_n)
    if (!preset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/apb_completer.sv
// apb_completer: APB register completer with configurable wait states and registered response
module apb_completer
  import apb_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [WIDTH-1:0] paddr,
  input  logic [WIDTH-1:0] pwdata,
  output logic             pready,
  output logic [WIDTH-1:0] prdata,
  output logic             pslverr
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  state_e state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, prdata_q, prdata_d, rdata;
  logic write_q, write_d, pready_q, pready_d, pslverr_q, pslverr_d;
  logic setup, err, to_done, commit;
  // response is computed from the address about to be held, so zero wait states still lands one cycle after setup
  always_comb begin
    setup = state_q == IDLE && psel && !penable;
    addr_d = setup ? paddr : addr_q;
    write_d = setup ? pwrite : write_q;
    wdata_d = setup ? pwdata : wdata_q;
    err = addr_d >= WIDTH'(DEPTH) || (write_d && addr_d == WIDTH'(DEPTH - 1));
    state_d = state_q == IDLE ? (setup ? (WAIT_STATES > 0 ? WAIT : DONE) : IDLE)
            : state_q == WAIT ? (!psel ? IDLE : wait_q == 3'd0 ? DONE : WAIT)
            : IDLE;
    wait_d = setup ? WAIT_LOAD : (state_q == WAIT && wait_q != 3'd0) ? wait_q - 3'd1 : wait_q;
    to_done = state_d == DONE;
    pready_d = to_done;
    pslverr_d = (to_done && err) ? RESP_ERROR : RESP_OKAY;
    prdata_d = (to_done && !write_d && !err) ? rdata : '0;
    commit = state_q == DONE && psel && penable && pslverr_q == RESP_OKAY;
  end
  always_ff @(posedge pclk or negedge preset_n)
    if (!preset_n) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  apb_completer_regs #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_regs (
    .pclk     (pclk),
    .preset_n (preset_n),
    .we       (commit && write_q),
    .waddr    (addr_q[AW-1:0]),
    .wdata    (wdata_q),
    .inc      (commit),
    .raddr    (addr_d[AW-1:0]),
    .rdata    (rdata)
  );
  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;
endmodule

// File: tb/tb_apb_completer.sv
// tb_apb_completer: directed checks on three instances (2 wait states, 0 wait states, 8-bit wrap)
module tb_apb_completer;
  logic pclk = 1'b0, preset_n = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [2:0] psel_v = '0;
  logic [15:0] paddr = '0, pwdata = '0;
  logic pready_a, pready_b, pready_c, pslverr_a, pslverr_b, pslverr_c;
  logic [15:0] prdata_a, prdata_b;
  logic [7:0] prdata_c;
  int vec = 0, mis = 0;

  always #5 pclk = ~pclk;

  apb_completer #(.WIDTH(16), .DEPTH(16), .WAIT_STATES(2)) dut (
    .pclk(pclk), .preset_n(preset_n), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready_a), .prdata(prdata_a), .pslverr(pslverr_a));
  apb_completer #(.WIDTH(16), .DEPTH(16), .WAIT_STATES(0)) dut0 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready_b), .prdata(prdata_b), .pslverr(pslverr_b));
  apb_completer #(.WIDTH(8), .DEPTH(16), .WAIT_STATES(0)) dut8 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr[7:0]), .pwdata(pwdata[7:0]), .pready(pready_c), .prdata(prdata_c), .pslverr(pslverr_c));

  function automatic logic rdy(input int id);
    return id == 0 ? pready_a : id == 1 ? pready_b : pready_c;
  endfunction
  function automatic logic [15:0] rdat(input int id);
    return id == 0 ? prdata_a : id == 1 ? prdata_b : {8'h00, prdata_c};
  endfunction
  function automatic logic rerr(input int id);
    return id == 0 ? pslverr_a : id == 1 ? pslverr_b : pslverr_c;
  endfunction

  // setup then access; returns at the negedge where pready is seen, select still held
  task automatic xfer(input int id, input logic wr, input logic [15:0] a, input logic [15:0] d,
                      output logic [15:0] rd, output logic er, output int lat);
    @(negedge pclk);
    psel_v = '0;
    psel_v[id] = 1'b1;
    penable = 1'b0;
    pwrite = wr;
    paddr = a;
    pwdata = d;
    @(negedge pclk);
    penable = 1'b1;
    lat = 1;
    while (!rdy(id) && lat < 20) begin
      @(negedge pclk);
      lat++;
    end
    rd = rdat(id);
    er = rerr(id);
  endtask

  task automatic idle();
    @(negedge pclk);
    psel_v = '0;
    penable = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge pclk);
    vec++; if (pready_a !== 1'b0) begin mis++; $display("FAIL reset_pready got %b exp 0", pready_a); end
    vec++; if (prdata_a !== 16'h0) begin mis++; $display("FAIL reset_prdata got %h exp 0000", prdata_a); end
    vec++; if (pslverr_a !== 1'b0) begin mis++; $display("FAIL reset_pslverr got %b exp 0", pslverr_a); end
    vec++; if (pready_b !== 1'b0) begin mis++; $display("FAIL reset_pready0 got %b exp 0", pready_b); end
  endtask

  task automatic test_write_read();
    logic [15:0] rd; logic er; int lat;
    xfer(0, 1'b1, 16'd3, 16'h1234, rd, er, lat);
    vec++; if (lat !== 3) begin mis++; $display("FAIL wr3_latency got %0d exp 3", lat); end
    vec++; if (er !== 1'b0) begin mis++; $display("FAIL wr3_err got %b exp 0", er); end
    xfer(0, 1'b0, 16'd3, 16'h0, rd, er, lat);
    vec++; if (lat !== 3) begin mis++; $display("FAIL rd3_latency got %0d exp 3", lat); end
    vec++; if (rd !== 16'h1234) begin mis++; $display("FAIL rd3_data got %h exp 1234", rd); end
    vec++; if (er !== 1'b0) begin mis++; $display("FAIL rd3_err got %b exp 0", er); end
    xfer(0, 1'b0, 16'd15, 16'h0, rd, er, lat);
    vec++; if (rd !== 16'd2) begin mis++; $display("FAIL cnt_after_wr_rd got %h exp 0002", rd); end
    idle();
    vec++; if (pready_a !== 1'b0) begin mis++; $display("FAIL pready_one_cycle got %b exp 0", pready_a); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd; logic er; int lat;
    xfer(1, 1'b1, 16'd1, 16'h1111, rd, er, lat);
    vec++; if (lat !== 1) begin mis++; $display("FAIL b2b_wr1_latency got %0d exp 1", lat); end
    xfer(1, 1'b1, 16'd2, 16'h2222, rd, er, lat);
    vec++; if (lat !== 1) begin mis++; $display("FAIL b2b_wr2_latency got %0d exp 1", lat); end
    xfer(1, 1'b0, 16'd1, 16'h0, rd, er, lat);
    vec++; if (lat !== 1) begin mis++; $display("FAIL b2b_rd1_latency got %0d exp 1", lat); end
    vec++; if (rd !== 16'h1111) begin mis++; $display("FAIL b2b_rd1_data got %h exp 1111", rd); end
    xfer(1, 1'b0, 16'd2, 16'h0, rd, er, lat);
    vec++; if (rd !== 16'h2222) begin mis++; $display("FAIL b2b_rd2_data got %h exp 2222", rd); end
    xfer(1, 1'b0, 16'd15, 16'h0, rd, er, lat);
    vec++; if (rd !== 16'd4) begin mis++; $display("FAIL b2b_cnt got %h exp 0004", rd); end
    idle();
  endtask

  task automatic test_errors();
    logic [15:0] rd; logic er; int lat;
    xfer(0, 1'b0, 16'd20, 16'h0, rd, er, lat);
    vec++; if (er !== 1'b1) begin mis++; $display("FAIL rd20_err got %b exp 1", er); end
    vec++; if (rd !== 16'h0) begin mis++; $display("FAIL rd20_data got %h exp 0000", rd); end
    vec++; if (lat !== 3) begin mis++; $display("FAIL rd20_latency got %0d exp 3", lat); end
    xfer(0, 1'b1, 16'd15, 16'hBEEF, rd, er, lat);
    vec++; if (er !== 1'b1) begin mis++; $display("FAIL wr15_err got %b exp 1", er); end
    xfer(0, 1'b0, 16'd15, 16'h0, rd, er, lat);
    vec++; if (rd !== 16'd3) begin mis++; $display("FAIL cnt_after_err got %h exp 0003", rd); end
    vec++; if (er !== 1'b0) begin mis++; $display("FAIL rd15_err got %b exp 0", er); end
    idle();
    vec++; if (pslverr_a !== 1'b0) begin mis++; $display("FAIL pslverr_idle got %b exp 0", pslverr_a); end
  endtask

  task automatic test_abort();
    logic [15:0] rd; logic er; int lat;
    @(negedge pclk);
    psel_v = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 16'd5; pwdata = 16'hAAAA;
    @(negedge pclk);
    penable = 1'b1;
    vec++; if (pready_a !== 1'b0) begin mis++; $display("FAIL abort_wait1_pready got %b exp 0", pready_a); end
    @(negedge pclk);
    psel_v = '0; penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vec++; if (pready_a !== 1'b0) begin mis++; $display("FAIL abort_pready[%0d] got %b exp 0", i, pready_a); end
      @(negedge pclk);
    end
    xfer(0, 1'b0, 16'd5, 16'h0, rd, er, lat);
    vec++; if (rd !== 16'h0000) begin mis++; $display("FAIL abort_rd5 got %h exp 0000", rd); end
    xfer(0, 1'b0, 16'd15, 16'h0, rd, er, lat);
    vec++; if (rd !== 16'd5) begin mis++; $display("FAIL abort_cnt got %h exp 0005", rd); end
    idle();
  endtask

  task automatic test_penable_only();
    logic [15:0] rd; logic er; int lat;
    @(negedge pclk);
    psel_v = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 16'd6; pwdata = 16'h6666;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      vec++; if (pready_a !== 1'b0) begin mis++; $display("FAIL penable_only_pready[%0d] got %b exp 0", i, pready_a); end
    end
    idle();
    xfer(0, 1'b0, 16'd6, 16'h0, rd, er, lat);
    vec++; if (rd !== 16'h0000) begin mis++; $display("FAIL penable_only_rd6 got %h exp 0000", rd); end
    xfer(0, 1'b0, 16'd15, 16'h0, rd, er, lat);
    vec++; if (rd !== 16'd7) begin mis++; $display("FAIL penable_only_cnt got %h exp 0007", rd); end
    idle();
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd; logic er; int lat;
    xfer(0, 1'b1, 16'd7, 16'h7777, rd, er, lat);
    vec++; if (pready_a !== 1'b1) begin mis++; $display("FAIL mid_pready_before got %b exp 1", pready_a); end
    #2 preset_n = 1'b0;
    #1;
    vec++; if (pready_a !== 1'b0) begin mis++; $display("FAIL mid_async_pready got %b exp 0", pready_a); end
    vec++; if (pslverr_a !== 1'b0 || prdata_a !== 16'h0) begin mis++; $display("FAIL mid_async_outs got %b/%h exp 0/0000", pslverr_a, prdata_a); end
    psel_v = '0; penable = 1'b0;
    @(negedge pclk);
    preset_n = 1'b1;
    @(negedge pclk);
    vec++; if (pready_a !== 1'b0) begin mis++; $display("FAIL mid_after_release got %b exp 0", pready_a); end
    xfer(0, 1'b0, 16'd7, 16'h0, rd, er, lat);
    vec++; if (rd !== 16'h0000) begin mis++; $display("FAIL mid_rd7 got %h exp 0000", rd); end
    xfer(0, 1'b0, 16'd15, 16'h0, rd, er, lat);
    vec++; if (rd !== 16'd1) begin mis++; $display("FAIL mid_cnt got %h exp 0001", rd); end
    idle();
  endtask

  task automatic test_wrap();
    logic [15:0] rd; logic er; int lat;
    for (int i = 0; i < 254; i++) xfer(2, 1'b0, 16'd0, 16'h0, rd, er, lat);
    xfer(2, 1'b0, 16'd15, 16'h0, rd, er, lat);
    vec++; if (rd !== 16'h00FE) begin mis++; $display("FAIL wrap_fe got %h exp 00fe", rd); end
    xfer(2, 1'b0, 16'd15, 16'h0, rd, er, lat);
    vec++; if (rd !== 16'h00FF) begin mis++; $display("FAIL wrap_ff got %h exp 00ff", rd); end
    xfer(2, 1'b0, 16'd15, 16'h0, rd, er, lat);
    vec++; if (rd !== 16'h0000) begin mis++; $display("FAIL wrap_00 got %h exp 0000", rd); end
    idle();
  endtask

  initial begin
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_errors();
    test_abort();
    test_penable_only();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule

// File: doc/apb_completer.md
APB_COMPLETER -- requirements
Module: apb_completer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning data and address bus width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning number of word registers (power of two, 2..256).
REQ-003 SHALL have parameter WAIT_STATES, default 0, meaning pready delay in ACCESS cycles (0..7).
REQ-004 SHALL have port pclk  input  1  peripheral clock, all logic on rising edge.
REQ-005 SHALL have port preset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port psel  input  1  completer select from initiator.
REQ-007 SHALL have port penable  input  1  access phase strobe.
REQ-008 SHALL have port pwrite  input  1  1 = write, 0 = read.
REQ-009 SHALL have port paddr  input  WIDTH  register word index.
REQ-010 SHALL have port pwdata  input  WIDTH  write data.
REQ-011 SHALL have port pready  output  1  transfer complete, registered.
REQ-012 SHALL have port prdata  output  WIDTH  read data, registered.
REQ-013 SHALL have port pslverr  output  1  transfer error, registered.

Function
REQ-014 FSM states SHALL be IDLE, WAIT, DONE.
- IDLE -> WAIT on edge sampling psel=1, penable=0, when WAIT_STATES>0.
- IDLE -> DONE on the same condition when WAIT_STATES=0.
- WAIT -> DONE when wait count reaches 0.
- DONE -> IDLE unconditionally.
REQ-015 On the setup-sampling edge, the block SHALL latch paddr, pwrite, pwdata and load wait count = WAIT_STATES-1.
REQ-016 In WAIT the count SHALL decrement once per edge; transition to DONE when it equals 0.
REQ-017 Resulting timing: pready SHALL be 1 exactly in cycle setup+1+WAIT_STATES; 0 in all other cycles.
REQ-018 Registers 0..DEPTH-2 SHALL be read/write storage.
REQ-019 Register DEPTH-1 SHALL be a read-only WIDTH-bit transfer counter.
- Increments on each completed transfer with pslverr=0.
- Wraps from all-ones to 0.
REQ-020 Latched address >= DEPTH SHALL give pslverr=1: no write, prdata=0, counter unchanged.
REQ-021 A write to DEPTH-1 SHALL give pslverr=1, no update; counter unchanged.
REQ-022 A write SHALL commit on the DONE->IDLE edge only if psel=1 and penable=1 in that cycle.
REQ-023 For reads, prdata SHALL carry the addressed register value (counter value before any increment) while pready=1; otherwise prdata=0.
REQ-024 pslverr SHALL be 1 only while pready=1.
REQ-025 If psel drops in WAIT or DONE (initiator abort), the FSM SHALL return to IDLE next edge: no write, no counter increment, pready/pslverr low.
REQ-026 penable=1 seen in IDLE without a prior setup cycle SHALL be ignored (no response).
REQ-027 A back-to-back setup presented in the cycle after pready SHALL be accepted from IDLE with identical timing.

Reset
REQ-028 While preset_n=0, all of the following SHALL be 0, asynchronously: state=IDLE, all registers incl. counter, wait count, pready, prdata, pslverr.
REQ-029 Reset mid-transfer SHALL abort it: no write commit; block idle with outputs 0 on first edge after release.

Structure
REQ-030 Shared package apb_pkg SHALL hold:
- FSM state enum (IDLE, WAIT, DONE)
- Default WIDTH
- Response encodings (OKAY=0, ERROR=1)
REQ-031 Storage plus counter SHALL be one sub-module apb_completer_regs (read mux, write enable, counter); FSM and decode stay in apb_completer.

Verification (WIDTH=16, DEPTH=16, WAIT_STATES=2 unless noted)
REQ-032 Write 0x1234 to addr 3, then read addr 3:
- Each transfer: pready high exactly 3 cycles after setup.
- Read returns prdata=0x1234, pslverr=0.
- Counter reads 2.
REQ-033 WAIT_STATES=0, back-to-back writes to addrs 1 and 2, then reads of both:
- pready in the cycle right after each setup.
- Data returned intact.
REQ-034 Read addr 20 -> pslverr=1, prdata=0; write 0xBEEF to addr 15 -> pslverr=1; counter reads unchanged.
REQ-035 Write 0xAAAA to addr 5 with psel dropped in WAIT:
- No pready.
- Addr 5 reads 0x0000.
- Counter not incremented.
REQ-036 Assert preset_n=0 mid-write to addr 7:
- Outputs 0 immediately.
- After release, addr 7 reads 0 and counter reads 1 (that read only).
REQ-037 Force counter to 0xFFFF via 0xFFFF successful transfers, then one more -> reads 0x0000.
